// File: rtl/golden_nonce_reporter.sv
// Golden-nonce reporter: buffers hits in a small FIFO and streams each as a 6-byte frame
// (preamble, nonce MSB..LSB, XOR checksum) over a valid/ready byte interface.
module golden_nonce_reporter #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  PREAMBLE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hit_valid,
    input  logic [31:0]                hit_nonce,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                drop_count,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  LAST_IDX = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [31:0]        hold_q, hold_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [31:0]        mem_q [DEPTH];

    logic handshake;
    logic fifo_nonempty;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [7:0] frame_byte(input logic [31:0] nonce, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        unique case (idx)
            3'd0:    b = PREAMBLE;
            3'd1:    b = nonce[31:24];
            3'd2:    b = nonce[23:16];
            3'd3:    b = nonce[15:8];
            3'd4:    b = nonce[7:0];
            3'd5:    b = nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign handshake     = tx_valid_q && tx_ready;
    assign fifo_nonempty = (count_q != '0);

    // A pop only ever loads the holding register from the registered count, so a hit written
    // this cycle can never reach the wire before it has sat in the FIFO for one edge.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            IDLE:    pop = fifo_nonempty;
            SEND:    pop = handshake && (idx_q == LAST_IDX) && fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    assign push = hit_valid && ((count_q < CNT_W'(DEPTH)) || pop);
    assign drop = hit_valid && !push;

    // NOTE: every combinational output gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
                    end else if (pop) begin
                        hold_d = mem_q[rd_ptr_q];
                        idx_d  = 3'd0;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase

        // The byte register is loaded with the byte the next state will present, so a stall
        // (no handshake) re-selects the same byte and the stream stays stable.
        tx_valid_d = (state_d == SEND);
        tx_data_d  = tx_valid_d ? frame_byte(hold_d, idx_d) : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            hold_q     <= 32'h0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count is enough to make
    // stale entries unreachable, and it keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= hit_nonce;
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign drop_count = drop_cnt_q;
    assign busy       = (state_q == SEND) || fifo_nonempty;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed, table-driven bench for golden_nonce_reporter: frame contents, stalls,
// back-to-back frames, FIFO overflow, reload-cycle push, reset mid-frame, drop saturation.
module tb_golden_nonce_reporter;

    logic        clk;
    logic        rst_n;
    logic        hit_valid;
    logic [31:0] hit_nonce;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [2:0]  fifo_count;
    logic [15:0] drop_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    golden_nonce_reporter #(.DEPTH(4), .PREAMBLE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit_valid  (hit_valid),
        .hit_nonce  (hit_nonce),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] nonce;
        logic [47:0] frame;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [47:0] frame_of(input logic [31:0] n);
        return {8'hA5, n, n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]};
    endfunction

    // Checks six bytes starting at the current negedge, one per cycle (tx_ready must be 1).
    task automatic check_frame(input logic [47:0] f, input string name);
        for (int i = 0; i < 6; i++) begin
            check({name, "_valid"}, 32'(tx_valid), 32'd1);
            check({name, "_byte"}, 32'(tx_data), 32'(f[47-8*i -: 8]));
            tick();
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_idle_valid"}, 32'(tx_valid), 32'd0);
        check({name, "_idle_data"}, 32'(tx_data), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic hit_burst(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            hit_valid = 1'b1;
            hit_nonce = first + 32'(k);
            tick();
        end
        hit_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{nonce: 32'hDEADBEEF, frame: 48'hA5_DE_AD_BE_EF_22};
        vecs[1] = '{nonce: 32'h12345678, frame: 48'hA5_12_34_56_78_08};
        vecs[2] = '{nonce: 32'hFFFFFFFF, frame: 48'hA5_FF_FF_FF_FF_00};
        vecs[3] = '{nonce: 32'h00000000, frame: 48'hA5_00_00_00_00_00};
        vecs[4] = '{nonce: 32'h80000001, frame: 48'hA5_80_00_00_01_81};
        vecs[5] = '{nonce: 32'hCAFEF00D, frame: 48'hA5_CA_FE_F0_0D_C9};

        rst_n     = 1'b0;
        hit_valid = 1'b0;
        hit_nonce = 32'h0;
        tx_ready  = 1'b1;
        repeat (3) tick();

        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frame with latency checks.
        hit_burst(32'hDEADBEEF, 1);
        check("lat_count_after_write", 32'(fifo_count), 32'd1);
        check("lat_valid_after_write", 32'(tx_valid), 32'd0);
        check("lat_busy_after_write", 32'(busy), 32'd1);
        tick();
        check("lat_count_after_pop", 32'(fifo_count), 32'd0);
        check_frame(48'hA5_DE_AD_BE_EF_22, "t1");
        check_idle("t1");

        // Table of hand-computed frames.
        for (int v = 0; v < 6; v++) begin
            hit_burst(vecs[v].nonce, 1);
            tick();
            check_frame(vecs[v].frame, "table");
            check_idle("table");
        end

        // Stall for three cycles while byte AD is presented.
        hit_burst(32'hDEADBEEF, 1);
        tick();
        check("t2_b0", 32'(tx_data), 32'hA5);
        tick();
        check("t2_b1", 32'(tx_data), 32'hDE);
        tick();
        check("t2_b2", 32'(tx_data), 32'hAD);
        tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t2_stall_valid", 32'(tx_valid), 32'd1);
            check("t2_stall_data", 32'(tx_data), 32'hAD);
        end
        tx_ready = 1'b1;
        tick();
        check("t2_b3", 32'(tx_data), 32'hBE);
        tick();
        check("t2_b4", 32'(tx_data), 32'hEF);
        tick();
        check("t2_b5", 32'(tx_data), 32'h22);
        tick();
        check_idle("t2");

        // Two hits on consecutive cycles: 12 contiguous bytes.
        hit_burst(32'd1, 2);
        check_frame(frame_of(32'd1), "t3_f1");
        check_frame(frame_of(32'd2), "t3_f2");
        check_idle("t3");

        // Overflow: six hits with the sink stalled.
        tx_ready = 1'b0;
        hit_burst(32'd1, 6);
        check("t4_fifo_count", 32'(fifo_count), 32'd4);
        check("t4_drop_count", 32'(drop_count), 32'd1);
        check("t4_head_byte", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        for (int f = 1; f <= 5; f++) check_frame(frame_of(32'(f)), "t4_frame");
        check_idle("t4");
        check("t4_drop_final", 32'(drop_count), 32'd1);

        // Full FIFO, hit coincides with the last-byte handshake that reloads.
        tx_ready = 1'b0;
        hit_burst(32'd10, 5);
        check("t5_full", 32'(fifo_count), 32'd4);
        tx_ready = 1'b1;
        begin
            logic [47:0] f10;
            f10 = frame_of(32'd10);
            for (int i = 0; i < 5; i++) begin
                check("t5_f10_byte", 32'(tx_data), 32'(f10[47-8*i -: 8]));
                tick();
            end
            check("t5_f10_last", 32'(tx_data), 32'(f10[7:0]));
        end
        hit_valid = 1'b1;
        hit_nonce = 32'd15;
        tick();
        hit_valid = 1'b0;
        check("t5_count_after", 32'(fifo_count), 32'd4);
        check("t5_drop_after", 32'(drop_count), 32'd1);
        for (int f = 11; f <= 15; f++) check_frame(frame_of(32'(f)), "t5_frame");
        check_idle("t5");

        // Reset in the middle of a frame with two entries queued.
        tx_ready = 1'b0;
        hit_burst(32'd20, 3);
        check("t6_queued", 32'(fifo_count), 32'd2);
        tx_ready = 1'b1;
        tick();
        tick();
        check("t6_byte2", 32'(tx_data), 32'h00);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_data", 32'(tx_data), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_drop", 32'(drop_count), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_no_resume", 32'(tx_valid), 32'd0);
        end
        check("t6_count_post", 32'(fifo_count), 32'd0);

        // Drop counter saturation from a preloaded value.
        force dut.drop_cnt_q = 16'hFFFE;
        tick();
        release dut.drop_cnt_q;
        check("t7_preload", 32'(drop_count), 32'hFFFE);
        tx_ready = 1'b0;
        hit_burst(32'd100, 8);
        check("t7_drop_sat", 32'(drop_count), 32'hFFFF);
        check("t7_fifo_full", 32'(fifo_count), 32'd4);
        tick();
        check("t7_drop_hold", 32'(drop_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
